// File: rtl/spi_shift_ctrl_if.sv
// rtl/spi_shift_ctrl_if.sv - parallel handshake and serial pin bundle for spi_shift_ctrl
//
// Purpose: groups the word-level transmit/receive handshake and the SPI pins.
// Signals:
//   tx_data/tx_valid/tx_ready  word to send, request, accept qualifier
//   rx_data/rx_valid           received word, one-cycle update pulse
//   busy                       frame in progress
//   sclk/cs_n/mosi/miso        SPI mode-0 pins
// Modports: master = controller view, slave = requester/peripheral view.

interface spi_shift_ctrl_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             busy;
   logic             sclk;
   logic             cs_n;
   logic             mosi;
   logic             miso;

   modport master (
      input  tx_data, tx_valid, miso,
      output tx_ready, rx_data, rx_valid, busy, sclk, cs_n, mosi
   );

   modport slave (
      output tx_data, tx_valid, miso,
      input  tx_ready, rx_data, rx_valid, busy, sclk, cs_n, mosi
   );
endinterface

// File: rtl/spi_shift_ctrl.sv
// rtl/spi_shift_ctrl.sv - mode-0 SPI master sequencing an 8-bit shift datapath
//
// Purpose: accepts a parallel word, shifts it out MSB-first on mosi while
// shifting miso in at the LSB, then returns the received word with a pulse.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous, active-low reset
//   bus  spi_shift_ctrl_if.master (tx/rx handshake, busy, sclk, cs_n, mosi, miso)
// Parameters: WIDTH frame length in bits, DIV clk cycles per sclk half-period (>= 1).

module spi_shift_ctrl #(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic              clk,
   input  logic              rst,
   spi_shift_ctrl_if.master  bus
);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, TRAIL} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] rx_data_q;
   logic             rx_valid_q;
   logic             rx_bit;
   logic [BW-1:0]    bit_cnt;
   logic [DW-1:0]    div_cnt;

   logic tx_ready_c;
   logic busy_c;
   logic sclk_c;
   logic cs_n_c;
   logic accept;
   logic div_last;
   logic last_bit;

   assign accept   = bus.tx_valid & tx_ready_c;
   assign div_last = (div_cnt == DIV_LAST);
   assign last_bit = (bit_cnt == BIT_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)   state_nxt = LOW;
         LOW:     if (div_last) state_nxt = HIGH;
         HIGH:    if (div_last) state_nxt = last_bit ? TRAIL : LOW;
         TRAIL:   if (div_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state only: sclk/cs_n/ready change exactly on the
   // edges where the state changes, so no input reaches an output combinationally.
   always_comb begin
      tx_ready_c = 1'b0;
      busy_c     = 1'b1;
      sclk_c     = 1'b0;
      cs_n_c     = 1'b0;
      case (state)
         IDLE: begin
            tx_ready_c = 1'b1;
            busy_c     = 1'b0;
            cs_n_c     = 1'b1;
         end
         HIGH:    sclk_c = 1'b1;
         default: ;
      endcase
   end

   // Datapath: miso captured as sclk rises, shifted in as sclk falls so mosi
   // only moves on falling edges (mode 0).
   always_ff @(posedge clk) begin
      if (!rst) begin
         shreg      <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_bit     <= 1'b0;
         bit_cnt    <= '0;
         div_cnt    <= '0;
      end else begin
         rx_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg   <= bus.tx_data;
                  bit_cnt <= '0;
                  div_cnt <= '0;
               end
            end
            LOW: begin
               if (div_last) begin
                  div_cnt <= '0;
                  rx_bit  <= bus.miso;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            HIGH: begin
               if (div_last) begin
                  div_cnt <= '0;
                  shreg   <= {shreg[WIDTH-2:0], rx_bit};
                  if (!last_bit) begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            TRAIL: begin
               if (div_last) begin
                  div_cnt    <= '0;
                  rx_data_q  <= shreg;
                  rx_valid_q <= 1'b1;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.tx_ready = tx_ready_c;
   assign bus.busy     = busy_c;
   assign bus.sclk     = sclk_c;
   assign bus.cs_n     = cs_n_c;
   assign bus.mosi     = shreg[WIDTH-1];
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_shift_ctrl.sv
// tb/tb_spi_shift_ctrl.sv - self-checking bench for spi_shift_ctrl
//
// Purpose: drives frames into a DIV=4 instance (a) and a DIV=1 instance (b),
// both WIDTH=8, and checks timing, data and reset behaviour against a
// scoreboard of expected received words.

module tb_spi_shift_ctrl;
   localparam int W     = 8;
   localparam int DA    = 4;
   localparam int DB    = 1;
   localparam int LAT_A = (2 * W + 1) * DA;
   localparam int LAT_B = (2 * W + 1) * DB;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_shift_ctrl_if #(.WIDTH(W)) a_if ();
   spi_shift_ctrl_if #(.WIDTH(W)) b_if ();

   logic loop_a;
   logic miso_a;
   assign a_if.miso = loop_a ? a_if.mosi : miso_a;
   assign b_if.miso = b_if.mosi;

   spi_shift_ctrl #(.WIDTH(W), .DIV(DA)) u_a (.clk(clk), .rst(rst), .bus(a_if.master));
   spi_shift_ctrl #(.WIDTH(W), .DIV(DB)) u_b (.clk(clk), .rst(rst), .bus(b_if.master));

   int checks = 0;
   int errors = 0;
   logic [W-1:0] sb[$];
   int rise_t[16];

   // Selected-instance view used by the frame helpers
   logic         sel;
   logic         m_sclk, m_mosi, m_rx_valid, m_tx_ready;
   logic [W-1:0] m_rx_data;
   assign m_sclk     = sel ? b_if.sclk     : a_if.sclk;
   assign m_mosi     = sel ? b_if.mosi     : a_if.mosi;
   assign m_rx_valid = sel ? b_if.rx_valid : a_if.rx_valid;
   assign m_tx_ready = sel ? b_if.tx_ready : a_if.tx_ready;
   assign m_rx_data  = sel ? b_if.rx_data  : a_if.rx_data;

   // Waits for tx_ready, presents d with tx_valid, returns at the negedge after
   // the accept edge. tx_valid is left asserted for the caller to manage.
   task automatic start(input logic [W-1:0] d, output logic ok);
      int n;
      ok = 1'b0;
      n  = 0;
      @(negedge clk);
      while (!m_tx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (m_tx_ready) ok = 1'b1;
      if (sel) begin
         b_if.tx_data  = d;
         b_if.tx_valid = 1'b1;
      end else begin
         a_if.tx_data  = d;
         a_if.tx_valid = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Observes one frame starting at the negedge after its accept edge (cyc 0).
   task automatic watch(input int mlim, output logic [W-1:0] rx, output int lat,
                        output int nrise, output logic [W-1:0] mseq,
                        output logic mosi_or, output logic rdy_seen);
      int   cyc;
      logic prev;
      rx = '0; lat = -1; nrise = 0; mseq = '0; mosi_or = 1'b0; rdy_seen = 1'b0;
      prev = 1'b0;
      cyc  = 0;
      while (cyc <= 400) begin
         if (m_sclk && !prev) begin
            if (nrise < 16) rise_t[nrise] = cyc;
            nrise++;
            mseq = {mseq[W-2:0], m_mosi};
         end
         prev = m_sclk;
         if (cyc < mlim) mosi_or = mosi_or | m_mosi;
         if (m_rx_valid) begin
            lat = cyc;
            rx  = m_rx_data;
            break;
         end
         if (m_tx_ready) rdy_seen = 1'b1;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      logic [11:0] got;
      rst    = 1'b0;
      loop_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_if.tx_data  = W'($urandom);
         a_if.tx_valid = 1'($urandom);
         b_if.tx_data  = W'($urandom);
         b_if.tx_valid = 1'($urandom);
         miso_a        = 1'($urandom);
         @(negedge clk);
         got = {a_if.cs_n, a_if.sclk, a_if.rx_valid, a_if.busy, a_if.rx_data};
         checks++;
         if (got !== {4'b1000, 8'h00}) begin
            errors++;
            $display("FAIL reset_a cyc%0d: got %h expected %h", i, got, {4'b1000, 8'h00});
         end
         got = {b_if.cs_n, b_if.sclk, b_if.rx_valid, b_if.busy, b_if.rx_data};
         checks++;
         if (got !== {4'b1000, 8'h00}) begin
            errors++;
            $display("FAIL reset_b cyc%0d: got %h expected %h", i, got, {4'b1000, 8'h00});
         end
      end
      a_if.tx_valid = 1'b0;
      b_if.tx_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({a_if.tx_ready, b_if.tx_ready, a_if.cs_n} !== 3'b111) begin
         errors++;
         $display("FAIL reset_release_ready: got %b expected 111",
                  {a_if.tx_ready, b_if.tx_ready, a_if.cs_n});
      end
   endtask

   task automatic test_loopback();
      logic [W-1:0] rx, mseq, exp;
      int lat, nrise, bad;
      logic ok, mor, rdy;
      sel = 1'b0; loop_a = 1'b1;
      start(8'hA5, ok);
      a_if.tx_valid = 1'b0;
      sb.push_back(8'hA5);
      watch(2 * W * DA, rx, lat, nrise, mseq, mor, rdy);
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      checks++;
      if (!ok) begin errors++; $display("FAIL loop_accept: got tx_ready 0 expected 1"); end
      checks++;
      if (lat !== LAT_A) begin errors++; $display("FAIL loop_latency: got %0d expected %0d", lat, LAT_A); end
      checks++;
      if (rx !== exp) begin errors++; $display("FAIL loop_rx_data: got %h expected %h", rx, exp); end
      checks++;
      if (nrise !== W) begin errors++; $display("FAIL loop_sclk_pulses: got %0d expected %0d", nrise, W); end
      checks++;
      if (mseq !== 8'hA5) begin errors++; $display("FAIL loop_mosi_seq: got %b expected %b", mseq, 8'hA5); end
      bad = 0;
      for (int k = 0; k < W; k++) if (rise_t[k] != (2 * k + 1) * DA) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL loop_sclk_rise_times: got %0d misplaced expected 0 (first at %0d)", bad, rise_t[0]); end
      checks++;
      if (rdy !== 1'b0) begin errors++; $display("FAIL loop_ready_low_in_frame: got %b expected 0", rdy); end
      @(negedge clk);
      checks++;
      if (a_if.rx_valid !== 1'b0) begin errors++; $display("FAIL loop_rx_valid_pulse: got %b expected 0", a_if.rx_valid); end
   endtask

   task automatic test_receive();
      logic [W-1:0] rx, mseq, exp;
      int lat, nrise;
      logic ok, mor, rdy;
      sel = 1'b0; loop_a = 1'b0; miso_a = 1'b1;
      start(8'h00, ok);
      a_if.tx_valid = 1'b0;
      sb.push_back(8'hFF);
      watch(2 * W * DA, rx, lat, nrise, mseq, mor, rdy);
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      checks++;
      if (mor !== 1'b0) begin errors++; $display("FAIL rx_only_mosi_low: got %b expected 0", mor); end
      checks++;
      if (rx !== exp) begin errors++; $display("FAIL rx_only_data: got %h expected %h", rx, exp); end
      checks++;
      if (lat !== LAT_A) begin errors++; $display("FAIL rx_only_latency: got %0d expected %0d", lat, LAT_A); end
      loop_a = 1'b1;
   endtask

   task automatic test_busy_ignore();
      logic [W-1:0] rx, mseq, exp;
      int lat, nrise;
      logic ok, mor, rdy;
      sel = 1'b0; loop_a = 1'b1;
      start(8'h81, ok);
      a_if.tx_data = 8'h3C;
      sb.push_back(8'h81);
      watch(2 * W * DA, rx, lat, nrise, mseq, mor, rdy);
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      checks++;
      if (rx !== exp) begin errors++; $display("FAIL busy_first_rx: got %h expected %h", rx, exp); end
      checks++;
      if (mseq !== 8'h81) begin errors++; $display("FAIL busy_first_mosi: got %h expected %h", mseq, 8'h81); end
      checks++;
      if (rdy !== 1'b0) begin errors++; $display("FAIL busy_ready_in_frame: got %b expected 0", rdy); end
      checks++;
      if (a_if.cs_n !== 1'b1) begin errors++; $display("FAIL busy_gap_cs_high: got %b expected 1", a_if.cs_n); end
      @(negedge clk);
      checks++;
      if ({a_if.cs_n, a_if.busy} !== 2'b01) begin
         errors++;
         $display("FAIL busy_second_accept: got cs_n,busy=%b expected 01", {a_if.cs_n, a_if.busy});
      end
      a_if.tx_valid = 1'b0;
      sb.push_back(8'h3C);
      watch(2 * W * DA, rx, lat, nrise, mseq, mor, rdy);
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      checks++;
      if (rx !== exp) begin errors++; $display("FAIL busy_second_rx: got %h expected %h", rx, exp); end
      checks++;
      if (lat !== LAT_A) begin errors++; $display("FAIL busy_second_latency: got %0d expected %0d", lat, LAT_A); end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] rx, mseq, exp;
      int lat, nrise, n, stray;
      logic ok, mor, rdy, prev;
      sel = 1'b0; loop_a = 1'b1;
      start(8'hC3, ok);
      a_if.tx_valid = 1'b0;
      sb.push_back(8'hC3);
      nrise = 0; n = 0; prev = 1'b0;
      while (nrise < 4 && n < 200) begin
         if (a_if.sclk && !prev) nrise++;
         prev = a_if.sclk;
         if (nrise < 4) begin
            @(negedge clk);
            n++;
         end
      end
      checks++;
      if (nrise !== 4) begin errors++; $display("FAIL midrst_find_rise: got %0d rises expected 4", nrise); end
      rst = 1'b0;
      @(negedge clk);
      sb.delete();
      checks++;
      if ({a_if.cs_n, a_if.sclk, a_if.busy, a_if.rx_valid} !== 4'b1000) begin
         errors++;
         $display("FAIL midrst_outputs: got %b expected 1000",
                  {a_if.cs_n, a_if.sclk, a_if.busy, a_if.rx_valid});
      end
      rst = 1'b1;
      stray = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (a_if.rx_valid) stray++;
      end
      checks++;
      if (stray != 0) begin errors++; $display("FAIL midrst_no_rx_valid: got %0d pulses expected 0", stray); end
      start(8'h5A, ok);
      a_if.tx_valid = 1'b0;
      sb.push_back(8'h5A);
      watch(2 * W * DA, rx, lat, nrise, mseq, mor, rdy);
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      checks++;
      if (rx !== exp || lat !== LAT_A) begin
         errors++;
         $display("FAIL midrst_next_frame: got %h at %0d expected %h at %0d", rx, lat, exp, LAT_A);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] rx, mseq, exp;
      int lat, lat1, nrise, bad, period;
      logic ok, mor, rdy;
      sel = 1'b1;
      start(8'hFF, ok);
      b_if.tx_data = 8'h01;
      sb.push_back(8'hFF);
      watch(2 * W * DB, rx, lat1, nrise, mseq, mor, rdy);
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      checks++;
      if (lat1 !== LAT_B) begin errors++; $display("FAIL div1_latency1: got %0d expected %0d", lat1, LAT_B); end
      checks++;
      if (rx !== exp) begin errors++; $display("FAIL div1_rx1: got %h expected %h", rx, exp); end
      bad = 0;
      for (int k = 0; k < W; k++) if (rise_t[k] != 2 * k + 1) bad++;
      checks++;
      if (bad != 0 || nrise != W) begin
         errors++;
         $display("FAIL div1_sclk_period: got %0d misplaced of %0d rises expected 0 of %0d", bad, nrise, W);
      end
      @(negedge clk);
      period = (b_if.busy && !b_if.cs_n) ? lat1 + 1 : -1;
      checks++;
      if (period !== LAT_B + 1) begin errors++; $display("FAIL div1_b2b_period: got %0d expected %0d", period, LAT_B + 1); end
      b_if.tx_valid = 1'b0;
      sb.push_back(8'h01);
      watch(2 * W * DB, rx, lat, nrise, mseq, mor, rdy);
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      checks++;
      if (rx !== exp || lat !== LAT_B) begin
         errors++;
         $display("FAIL div1_frame2: got %h at %0d expected %h at %0d", rx, lat, exp, LAT_B);
      end
      sel = 1'b0;
   endtask

   initial begin
      sel = 1'b0;
      loop_a = 1'b1;
      miso_a = 1'b0;
      a_if.tx_data = '0; a_if.tx_valid = 1'b0;
      b_if.tx_data = '0; b_if.tx_valid = 1'b0;
      test_reset();
      test_loopback();
      test_receive();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_shift_ctrl.md
# spi_shift_ctrl

Sequencer for an 8-bit serial shift datapath, configured as a mode-0 SPI master.
- Accepts a parallel word over a valid/ready handshake and loads it into an internal shift register.
- Generates sclk/cs_n and shifts the word out MSB-first on mosi while shifting miso in at the LSB.
- Returns the received word with a one-cycle valid pulse.
- Sits between the parallel control logic and off-chip or on-chip serial peripherals.

## Interface
Parameters:
- WIDTH, 8, frame length in bits; also the width of tx_data and rx_data.
- DIV, 4, clk cycles per sclk half-period; legal values are DIV ≥ 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-low.
- tx_data  input  WIDTH  word to transmit; sampled on accept.
- tx_valid  input  1  transmit request.
- tx_ready  output  1  high only in IDLE; accept = tx_valid & tx_ready at a clk edge.
- rx_data  output  WIDTH  last received word; holds until the next frame completes.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  high in every state except IDLE.
- sclk  output  1  serial clock, idles low (CPOL=0).
- cs_n  output  1  chip select, active low.
- mosi  output  1  serial out = shreg[WIDTH-1].
- miso  input  1  serial in; assumed synchronous to clk (synchroniser external).

## Operation
- Registers:
  - shreg[WIDTH-1:0]
  - rx_bit: 1-bit miso sample
  - bit_cnt: 0..WIDTH-1
  - div_cnt: 0..DIV-1
  - state: IDLE, LOW, HIGH, TRAIL
- IDLE: cs_n=1, sclk=0, tx_ready=1. On accept: shreg<=tx_data, bit_cnt<=0, div_cnt<=0, cs_n<=0, go to LOW.
- LOW:
  - sclk=0 for DIV cycles.
  - On the last cycle: sclk<=1, rx_bit<=miso, go to HIGH.
- HIGH:
  - sclk=1 for DIV cycles.
  - On the last cycle: sclk<=0 and shreg<={shreg[WIDTH-2:0], rx_bit}.
  - If bit_cnt==WIDTH-1, go to TRAIL; else bit_cnt<=bit_cnt+1 and go to LOW.
- TRAIL:
  - sclk=0, cs_n=0 for DIV cycles.
  - On the last cycle: cs_n<=1, rx_data<=shreg, rx_valid<=1, go to IDLE.
- mosi changes only on sclk falling edges (and at load). miso is sampled on the clk edge where sclk rises. This is mode 0.
- tx_valid while tx_ready=0 is ignored. tx_data is not captured and no error is raised. The requester must hold tx_valid until accepted.
- rx_valid is a pulse. It is deasserted in every cycle except the one following frame completion.
- Reset (rst=0 at any edge, including mid-frame) forces:
  - state=IDLE
  - outputs: cs_n=1, sclk=0, rx_valid=0, rx_data=0, busy=0, tx_ready=1 after release
  - internal: shreg=0, bit_cnt=0, div_cnt=0
- An interrupted frame produces no rx_valid.

## Timing
- Let E0 be the accept edge. Each frame event then occurs at a fixed edge:
  - E0: cs_n falls, mosi=tx_data[WIDTH-1], busy rises, tx_ready falls.
  - First sclk rise at E0+DIV, which gives DIV cycles of cs-to-sclk setup.
  - Bit k: sclk rises at E0+(2k+1)·DIV and falls at E0+(2k+2)·DIV, for k=0..WIDTH-1.
  - Last sclk fall at E0+2·WIDTH·DIV.
  - cs_n rises, rx_valid=1, rx_data valid and busy falls at E0+(2·WIDTH+1)·DIV. For defaults this is E0+68.
- Between frames, cs_n stays high for at least 1 cycle, because tx_ready is only asserted in IDLE.
- Back-to-back frame period is (2·WIDTH+1)·DIV+1 cycles.
- sclk duty cycle is exactly 50%, with period 2·DIV clk cycles.
- No combinational path from tx_valid or miso to any output. tx_ready is decoded from state only.

## Test plan
- Reset: hold rst=0 for 3 cycles with random inputs.
  - Required: cs_n=1, sclk=0, rx_valid=0, rx_data=0x00, busy=0, then tx_ready=1 after release.
- Loopback, defaults: miso tied to mosi, send 0xA5.
  - Required: 8 sclk pulses of period 8 cycles, mosi bit sequence 1,0,1,0,0,1,0,1.
  - Required: rx_valid for exactly 1 cycle at E0+68, with rx_data=0xA5.
- Independent receive: miso held at 1, send 0x00.
  - Required: mosi stays 0 for the whole frame, and rx_data=0xFF.
- Busy ignore: assert tx_valid with 0x3C during a frame carrying 0x81.
  - Required: 0x3C is neither transmitted nor captured until IDLE, then it is accepted on the first IDLE cycle.
  - Required: cs_n high for exactly 1 cycle between the two frames.
- Reset mid-frame: apply rst=0 after the 4th sclk rise.
  - Required: cs_n=1 and sclk=0 on the next edge, and no rx_valid.
  - Required: the next frame, 0x5A loopback, returns 0x5A.
- DIV=1, WIDTH=8: two consecutive frames, 0xFF then 0x01.
  - Required: each frame lasts 17 cycles from accept to rx_valid.
  - Required: sclk period is 2 cycles and the back-to-back period is 18 cycles.
